// File: rtl/seg_display_arbiter.sv
// Two-source frame arbiter for a multi-cell segment display: round-robin grant,
// minimum dwell per frame, and blanking after a request-free idle period.
module seg_display_arbiter #(
    parameter int unsigned NUMCELLS     = 4,
    parameter int unsigned DWELL        = 10000,
    parameter int unsigned IDLE_TIMEOUT = 40000,
    parameter logic [7:0]  BLANK_CELL   = 8'hFF
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req0,
    input  logic [8*NUMCELLS-1:0]   data0,
    output logic                    ack0,
    input  logic                    req1,
    input  logic [8*NUMCELLS-1:0]   data1,
    output logic                    ack1,
    output logic [8*NUMCELLS-1:0]   cellvalout,
    output logic [1:0]              owner,
    output logic                    busy
);

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [8*NUMCELLS-1:0] BLANK_FRAME  = {NUMCELLS{BLANK_CELL}};
    localparam logic [DW-1:0]         DWELL_RELOAD = DW'(DWELL - 1);
    localparam logic [IW-1:0]         IDLE_LIMIT   = IW'(IDLE_TIMEOUT);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [DW-1:0]           dwell_q, dwell_d;
    logic [IW-1:0]           idle_q, idle_d;
    logic                    last1_q, last1_d;   // 1: source 1 was granted last
    logic [8*NUMCELLS-1:0]   frame_q, frame_d;
    logic [1:0]              owner_q, owner_d;
    logic                    ack0_q, ack0_d;
    logic                    ack1_q, ack1_d;

    logic grant_ev;
    logic pick1;

    assign grant_ev = ((state_q == IDLE) || (dwell_q == '0)) && (req0 || req1);
    assign pick1    = req1 && (!req0 || !last1_q);

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        idle_d  = idle_q;
        last1_d = last1_q;
        frame_d = frame_q;
        owner_d = owner_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;

        // A grant takes precedence over both the HOLD countdown and blanking.
        if (grant_ev) begin
            frame_d = pick1 ? data1 : data0;
            owner_d = pick1 ? 2'b10 : 2'b01;
            ack0_d  = !pick1;
            ack1_d  = pick1;
            dwell_d = DWELL_RELOAD;
            state_d = HOLD;
            last1_d = pick1;
            idle_d  = '0;
        end else if (state_q == HOLD) begin
            if (dwell_q == '0) begin
                state_d = IDLE;
            end else begin
                dwell_d = dwell_q - DW'(1);
            end
        end else if ((IDLE_TIMEOUT != 0) && (idle_q != IDLE_LIMIT)) begin
            idle_d = idle_q + IW'(1);
            if (idle_d == IDLE_LIMIT) begin
                frame_d = BLANK_FRAME;
                owner_d = 2'b00;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dwell_q <= '0;
            idle_q  <= '0;
            last1_q <= 1'b1;
            frame_q <= BLANK_FRAME;
            owner_q <= 2'b00;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            idle_q  <= idle_d;
            last1_q <= last1_d;
            frame_q <= frame_d;
            owner_q <= owner_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    assign cellvalout = frame_q;
    assign owner      = owner_q;
    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign busy       = (state_q == HOLD);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed self-checking bench for seg_display_arbiter (DWELL=4, IDLE_TIMEOUT=8).
module tb_seg_display_arbiter;

    logic        clock;
    logic        reset_n;
    logic        req0, req1;
    logic [31:0] data0, data1;
    logic        ack0, ack1;
    logic [31:0] cellvalout;
    logic [1:0]  owner;
    logic        busy;

    int unsigned checks;
    int unsigned passed;

    seg_display_arbiter #(
        .NUMCELLS     (4),
        .DWELL        (4),
        .IDLE_TIMEOUT (8),
        .BLANK_CELL   (8'hFF)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0       (req0),
        .data0      (data0),
        .ack0       (ack0),
        .req1       (req1),
        .data1      (data1),
        .ack1       (ack1),
        .cellvalout (cellvalout),
        .owner      (owner),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks += 1;
        if (cellvalout !== 32'hFFFFFFFF) $display("FAIL reset_cellval got %h exp %h", cellvalout, 32'hFFFFFFFF);
        else passed += 1;
        checks += 1;
        if (owner !== 2'b00) $display("FAIL reset_owner got %b exp %b", owner, 2'b00);
        else passed += 1;
        checks += 1;
        if ({ack0, ack1, busy} !== 3'b000) $display("FAIL reset_ack_busy got %b exp %b", {ack0, ack1, busy}, 3'b000);
        else passed += 1;
        reset_n = 1'b1;
    endtask

    // Single grant followed by idle blanking after 4 HOLD + 8 IDLE cycles.
    task automatic test_single_and_timeout();
        req0 = 1'b1; data0 = 32'h12345678;
        @(negedge clock);
        checks += 1;
        if (cellvalout !== 32'h12345678) $display("FAIL single_cellval got %h exp %h", cellvalout, 32'h12345678);
        else passed += 1;
        checks += 1;
        if ({ack0, ack1} !== 2'b10) $display("FAIL single_ack got %b exp %b", {ack0, ack1}, 2'b10);
        else passed += 1;
        checks += 1;
        if (owner !== 2'b01) $display("FAIL single_owner got %b exp %b", owner, 2'b01);
        else passed += 1;
        checks += 1;
        if (busy !== 1'b1) $display("FAIL single_busy0 got %b exp %b", busy, 1'b1);
        else passed += 1;
        req0 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            checks += 1;
            if ({ack0, busy} !== 2'b01) $display("FAIL single_hold k=%0d got %b exp %b", k, {ack0, busy}, 2'b01);
            else passed += 1;
        end
        @(negedge clock);
        checks += 1;
        if (busy !== 1'b0) $display("FAIL single_idle_busy got %b exp %b", busy, 1'b0);
        else passed += 1;
        for (int k = 5; k <= 11; k++) begin
            @(negedge clock);
            checks += 1;
            if ({owner, cellvalout} !== {2'b01, 32'h12345678})
                $display("FAIL timeout_retain k=%0d got %b/%h exp %b/%h", k, owner, cellvalout, 2'b01, 32'h12345678);
            else passed += 1;
        end
        @(negedge clock);
        checks += 1;
        if ({owner, cellvalout} !== {2'b00, 32'hFFFFFFFF})
            $display("FAIL timeout_blank got %b/%h exp %b/%h", owner, cellvalout, 2'b00, 32'hFFFFFFFF);
        else passed += 1;
    endtask

    // A request landing on the timeout edge is granted instead of blanking.
    task automatic test_timeout_race();
        req1 = 1'b1; data1 = 32'hAABBCCDD;
        @(negedge clock);
        checks += 1;
        if ({ack1, owner, cellvalout} !== {1'b1, 2'b10, 32'hAABBCCDD})
            $display("FAIL race_grant1 got %b/%b/%h exp 1/10/aabbccdd", ack1, owner, cellvalout);
        else passed += 1;
        req1 = 1'b0;
        repeat (11) @(negedge clock);
        req0 = 1'b1; data0 = 32'h0BADF00D;
        @(negedge clock);
        checks += 1;
        if ({ack0, owner, cellvalout} !== {1'b1, 2'b01, 32'h0BADF00D})
            $display("FAIL race_grant0 got %b/%b/%h exp 1/01/0badf00d", ack0, owner, cellvalout);
        else passed += 1;
        req0 = 1'b0;
        repeat (4) @(negedge clock);
        checks += 1;
        if (busy !== 1'b0) $display("FAIL race_idle got %b exp %b", busy, 1'b0);
        else passed += 1;
    endtask

    // Both requests held from reset: acks alternate every DWELL cycles, back to back.
    task automatic test_back_to_back();
        reset_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1; data0 = 32'h00000A0A; data1 = 32'h0000B1B1;
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic e0, e1;
            logic [31:0] ef;
            @(negedge clock);
            e0 = ((k % 8) == 0);
            e1 = ((k % 8) == 4);
            ef = ((k % 8) < 4) ? 32'h00000A0A : 32'h0000B1B1;
            checks += 1;
            if ({ack0, ack1} !== {e0, e1}) $display("FAIL rr_ack k=%0d got %b exp %b", k, {ack0, ack1}, {e0, e1});
            else passed += 1;
            checks += 1;
            if (cellvalout !== ef) $display("FAIL rr_cellval k=%0d got %h exp %h", k, cellvalout, ef);
            else passed += 1;
        end
        req0 = 1'b0; req1 = 1'b0;
        do_reset();
    endtask

    // req1 raised while source 0 holds: granted exactly DWELL cycles after ack0.
    task automatic test_pending();
        req0 = 1'b1; data0 = 32'h11112222;
        @(negedge clock);
        checks += 1;
        if (ack0 !== 1'b1) $display("FAIL pend_ack0 got %b exp %b", ack0, 1'b1);
        else passed += 1;
        req0 = 1'b0;
        req1 = 1'b1; data1 = 32'h33334444;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            checks += 1;
            if ({ack1, cellvalout} !== {1'b0, 32'h11112222})
                $display("FAIL pend_wait k=%0d got %b/%h exp 0/11112222", k, ack1, cellvalout);
            else passed += 1;
        end
        @(negedge clock);
        checks += 1;
        if ({ack0, ack1, owner, cellvalout} !== {2'b01, 2'b10, 32'h33334444})
            $display("FAIL pend_grant1 got %b%b/%b/%h exp 01/10/33334444", ack0, ack1, owner, cellvalout);
        else passed += 1;
        req1 = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    // Reset two cycles into HOLD aborts at once; a held request is granted right after release.
    task automatic test_reset_mid_hold();
        req0 = 1'b1; data0 = 32'h5A5A5A5A;
        @(negedge clock);
        req0 = 1'b0;
        repeat (2) @(negedge clock);
        req1 = 1'b1; data1 = 32'hC0DEC0DE;
        reset_n = 1'b0;
        #1;
        checks += 1;
        if ({busy, owner, cellvalout} !== {1'b0, 2'b00, 32'hFFFFFFFF})
            $display("FAIL midreset_outputs got %b/%b/%h exp 0/00/ffffffff", busy, owner, cellvalout);
        else passed += 1;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks += 1;
        if ({ack0, ack1, owner, cellvalout} !== {2'b01, 2'b10, 32'hC0DEC0DE})
            $display("FAIL midreset_regrant got %b%b/%b/%h exp 01/10/c0dec0de", ack0, ack1, owner, cellvalout);
        else passed += 1;
        req1 = 1'b0;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_single_and_timeout();
        test_timeout_race();
        test_back_to_back();
        test_pending();
        test_reset_mid_hold();
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    always @(negedge clock) begin
        if (ack0 === 1'b1 && ack1 === 1'b1) begin
            checks += 1;
            $display("FAIL ack_exclusive got %b%b exp not 11", ack0, ack1);
        end
    end

endmodule
